// File: rtl/io_controller.sv
// IO sequencer between the CPU's IN/OUT/HALT instructions and the 7-segment display unit.
// Debounces the confirm push-button and stalls the core while an IN waits for a press.
module io_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_in_req,
    input  logic        io_out_req,
    input  logic        halt_req,
    input  logic [31:0] out_data,
    input  logic        confirm_btn,
    input  logic [15:0] SW,
    output logic        stall,
    output logic        in_valid,
    output logic [31:0] in_data,
    output logic [31:0] num,
    output logic        output_flag,
    output logic        input_flag,
    output logic        halt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IN_WAIT = 2'd1;
    localparam logic [1:0] ST_IN_DONE = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_r;
    logic [1:0]       sync_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_valid_r;
    logic [31:0]      in_data_r;
    logic [31:0]      num_r;
    logic             output_flag_r;
    logic             input_flag_r;
    logic             halt_r;
    logic             stall_s;
    logic             unused_sw_s;

    // Only the low nibble of the switches is architecturally visible to IN.
    assign unused_sw_s = ^SW[15:4];

    // Synchronize the raw button, debounce it and emit a one-cycle press on each accepted rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r     <= 2'b00;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            sync_r     <= {sync_r[0], confirm_btn};
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
            if (sync_r[1] != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= sync_r[1];
                    cnt_r    <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Instruction sequencer; halt beats OUT beats IN, and HALTED is left only through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            in_valid_r    <= 1'b0;
            in_data_r     <= 32'd0;
            num_r         <= 32'd0;
            output_flag_r <= 1'b0;
            input_flag_r  <= 1'b0;
            halt_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (halt_req) begin
                        state_r <= ST_HALTED;
                        halt_r  <= 1'b1;
                    end else if (io_out_req) begin
                        num_r         <= out_data;
                        output_flag_r <= 1'b1;
                    end else if (io_in_req) begin
                        state_r       <= ST_IN_WAIT;
                        input_flag_r  <= 1'b1;
                        output_flag_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IN_WAIT: begin
                    // Presses seen before this state were consumed while idle and do not count.
                    if (halt_req) begin
                        state_r      <= ST_HALTED;
                        halt_r       <= 1'b1;
                        input_flag_r <= 1'b0;
                    end else if (press_r) begin
                        state_r    <= ST_IN_DONE;
                        in_data_r  <= {28'd0, SW[3:0]};
                        in_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_IN_WAIT;
                    end
                end
                ST_IN_DONE: begin
                    state_r      <= ST_IDLE;
                    in_valid_r   <= 1'b0;
                    input_flag_r <= 1'b0;
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                    halt_r  <= 1'b1;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    in_valid_r    <= 1'b0;
                    output_flag_r <= 1'b0;
                    input_flag_r  <= 1'b0;
                    halt_r        <= 1'b0;
                end
            endcase
        end
    end

    // Stall decode: the core freezes as soon as it presents an IN, without waiting a cycle.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE:    stall_s = io_in_req & ~halt_req;
            ST_IN_WAIT: stall_s = 1'b1;
            ST_IN_DONE: stall_s = 1'b0;
            ST_HALTED:  stall_s = 1'b1;
            default:    stall_s = 1'b0;
        endcase
    end

    assign stall       = stall_s;
    assign in_valid    = in_valid_r;
    assign in_data     = in_data_r;
    assign num         = num_r;
    assign output_flag = output_flag_r;
    assign input_flag  = input_flag_r;
    assign halt        = halt_r;

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: directed vector table, bounce/held-button sequences,
// and a randomized run against a behavioural model of the IO sequencing rules.
module tb_io_controller;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_in_req;
    logic        io_out_req;
    logic        halt_req;
    logic [31:0] out_data;
    logic        confirm_btn;
    logic [15:0] SW;
    logic        stall;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] num;
    logic        output_flag;
    logic        input_flag;
    logic        halt;

    io_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
        .clk(clk), .reset(reset), .io_in_req(io_in_req), .io_out_req(io_out_req),
        .halt_req(halt_req), .out_data(out_data), .confirm_btn(confirm_btn), .SW(SW),
        .stall(stall), .in_valid(in_valid), .in_data(in_data), .num(num),
        .output_flag(output_flag), .input_flag(input_flag), .halt(halt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int iv_count = 0;

    // Behavioural model state.
    typedef enum int {M_IDLE, M_WAIT, M_DONE, M_HALTED} mode_t;
    mode_t       m_mode = M_IDLE;
    bit          m_init = 1'b0;
    bit          m_sync0, m_sync1, m_stable, m_stable_prev, m_press;
    bit          hist[$];
    logic [31:0] m_num, m_in_data;
    bit          m_iv, m_of, m_if, m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_stall();
        return (m_mode == M_WAIT) || (m_mode == M_HALTED) ||
               (m_mode == M_IDLE && io_in_req && !halt_req);
    endfunction

    task automatic model_update();
        bit new_stable;
        bit all_diff;
        if (reset) begin
            m_mode = M_IDLE; m_init = 1'b1;
            m_sync0 = 0; m_sync1 = 0; m_stable = 0; m_stable_prev = 0; m_press = 0;
            hist.delete();
            m_num = 32'd0; m_in_data = 32'd0; m_iv = 0; m_of = 0; m_if = 0; m_halt = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (halt_req) begin m_mode = M_HALTED; m_halt = 1; end
                else if (io_out_req) begin m_num = out_data; m_of = 1; end
                else if (io_in_req) begin m_mode = M_WAIT; m_if = 1; m_of = 0; end
            end
            M_WAIT: begin
                if (halt_req) begin m_mode = M_HALTED; m_halt = 1; m_if = 0; end
                else if (m_press) begin m_mode = M_DONE; m_in_data = {28'd0, SW[3:0]}; m_iv = 1; end
            end
            M_DONE: begin m_mode = M_IDLE; m_iv = 0; m_if = 0; end
            default: ;
        endcase
        // Stable level flips once the synchronized level has disagreed for D consecutive samples.
        hist.push_back(m_sync1);
        if (hist.size() > D) void'(hist.pop_front());
        new_stable = m_stable;
        if (hist.size() == D) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i] == m_stable) all_diff = 1'b0;
            if (all_diff) begin new_stable = !m_stable; hist.delete(); end
        end
        m_press = m_stable && !m_stable_prev;
        m_stable_prev = m_stable;
        m_stable = new_stable;
        m_sync1 = m_sync0;
        m_sync0 = confirm_btn;
    endtask

    // One clock: check combinational stall, clock, update model, compare all outputs.
    task automatic step();
        #1;
        if (m_init && !reset) chk("stall_pre", stall, exp_stall());
        @(posedge clk);
        model_update();
        #1;
        if (m_init) begin
            chk("num", num, m_num);
            chk("in_data", in_data, m_in_data);
            chk("in_valid", in_valid, m_iv);
            chk("output_flag", output_flag, m_of);
            chk("input_flag", input_flag, m_if);
            chk("halt", halt, m_halt);
            chk("stall_post", stall, exp_stall());
        end
        if (in_valid === 1'b1) begin
            iv_count++;
            io_in_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; io_in_req = 0; io_out_req = 0; halt_req = 0;
        step(); step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit rst, hreq, oreq, ireq;
        logic [31:0] od;
        logic [31:0] e_num;
        bit e_of, e_if, e_halt, e_stall;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int lat;
        int seg_left;
        reset = 1'b1; io_in_req = 0; io_out_req = 0; halt_req = 0;
        out_data = 32'd0; confirm_btn = 1'b0; SW = 16'd0;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hdeadbeef, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd1234,     32'd1234, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd55,       32'd1234, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd7,        32'd7,    1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd7,        32'd7,    1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd7,        32'd7,    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd99,       32'd7,    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd99,       32'd7,    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0,    1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        32'd0,    1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0,    1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd5,        32'd0,    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0,    1'b0, 1'b0, 1'b0, 1'b0};

        // Directed vector table: reset, OUT, simultaneous OUT+IN, halt, reset out of IN_WAIT.
        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; halt_req = tbl[i].hreq; io_out_req = tbl[i].oreq;
            io_in_req = tbl[i].ireq; out_data = tbl[i].od; SW = 16'($urandom);
            step();
            chk($sformatf("tbl%0d_num", i), num, tbl[i].e_num);
            chk($sformatf("tbl%0d_of", i), output_flag, tbl[i].e_of);
            chk($sformatf("tbl%0d_if", i), input_flag, tbl[i].e_if);
            chk($sformatf("tbl%0d_halt", i), halt, tbl[i].e_halt);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
        end
        reset = 1'b0; halt_req = 0; io_out_req = 0; io_in_req = 0;

        // Bouncy button during an IN: 3-cycle glitches are rejected, then a clean hold.
        do_reset();
        SW = 16'h0009; io_in_req = 1'b1; confirm_btn = 1'b0;
        iv_count = 0;
        step();
        for (int g = 0; g < 4; g++) begin
            confirm_btn = 1'b1; repeat (3) step();
            confirm_btn = 1'b0; repeat (3) step();
        end
        chk("bounce_no_iv", iv_count, 0);
        confirm_btn = 1'b1; lat = -1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (in_valid === 1'b1 && lat < 0) begin
                lat = n;
                chk("bounce_in_data", in_data, 32'd9);
                chk("bounce_stall_done", stall, 1'b0);
            end else if (lat < 0) begin
                chk("bounce_stall_wait", stall, 1'b1);
            end else if (lat == n - 1) begin
                chk("bounce_if_clear", input_flag, 1'b0);
                chk("bounce_iv_drop", in_valid, 1'b0);
            end
        end
        chk("bounce_latency", lat, D + 4);
        chk("bounce_iv_once", iv_count, 1);
        confirm_btn = 1'b0;
        repeat (25) step();

        // Held button: a level already high when IN issues must be released and re-pressed.
        do_reset();
        SW = 16'h0005; confirm_btn = 1'b1;
        repeat (25) step();
        io_in_req = 1'b1; iv_count = 0;
        repeat (30) step();
        chk("held_no_iv", iv_count, 0);
        chk("held_stall", stall, 1'b1);
        confirm_btn = 1'b0;
        repeat (20) step();
        confirm_btn = 1'b1;
        repeat (40) step();
        chk("held_iv_once", iv_count, 1);
        chk("held_in_data", in_data, 32'd5);

        // Randomized traffic against the model.
        do_reset();
        seg_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!io_in_req) begin
                io_out_req = ($urandom % 5) == 0;
                io_in_req  = ($urandom % 8) == 0;
            end else begin
                io_out_req = 1'b0;
            end
            halt_req = ($urandom % 600) == 0;
            reset    = (m_mode == M_HALTED) ? (($urandom % 40) == 0) : (($urandom % 1000) == 0);
            out_data = $urandom;
            SW       = 16'($urandom);
            if (seg_left == 0) begin
                confirm_btn = 1'($urandom);
                seg_left = $urandom_range(1, 40);
            end
            seg_left--;
            step();
            if (reset) io_in_req = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Sequences the CPU's IN/OUT/HALT instructions onto the 7-segment display IO unit.
- Stalls the core while an IN waits for a debounced user confirm press on a push-button.
- Captures switch data and latches OUT values into `num`.
- Drives the `output_flag`, `input_flag` and `halt` controls consumed by the display unit.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a button level change. Board builds override this to about 500000.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- io_in_req  input  1  core is executing IN; held until stall drops
- io_out_req  input  1  core is executing OUT; single-cycle accept
- halt_req  input  1  core executed HALT
- out_data  input  32  value of the OUT instruction
- confirm_btn  input  1  raw push-button, active-high (board inversion done upstream), asynchronous
- SW  input  16  board switches
- stall  output  1  freeze core PC/pipeline
- in_valid  output  1  one-cycle pulse; in_data valid for the IN writeback
- in_data  output  32  captured input, {28'd0, SW[3:0]}
- num  output  32  latched OUT value to the display
- output_flag  output  1  display shows num
- input_flag  output  1  display shows live switch value
- halt  output  1  display shows halt banner

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: state=IDLE, num=0, in_data=0, in_valid=0, output_flag=0, input_flag=0, halt=0, debounce counter=0, stable level=0, sync FFs=0.
- Reset mid-operation, in any state, returns to IDLE next edge and drops all flags.
- Button conditioning:
  - 2-FF synchronizer on confirm_btn.
  - Counter increments while sync != stable and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still differing, stable flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
  - press = registered rising edge of stable (one-cycle pulse).
- FSM states: IDLE, IN_WAIT, IN_DONE, HALTED.
- Priority within IDLE: halt_req > io_out_req > io_in_req.
- IDLE:
  - halt_req -> HALTED, halt<=1.
  - Else io_out_req -> num<=out_data, output_flag<=1, input_flag unchanged (already 0), stay IDLE.
  - Else io_in_req -> IN_WAIT, input_flag<=1, output_flag<=0.
  - If io_out_req and io_in_req are both high, the OUT is taken this cycle and the IN on the next cycle.
- IN_WAIT:
  - halt_req -> HALTED (input_flag<=0).
  - press -> IN_DONE, in_data<={28'd0,SW[3:0]} sampled that edge, in_valid<=1.
  - A press that occurred before entering IN_WAIT does not count; a held button must be released and re-pressed.
- IN_DONE: single cycle; in_valid=1; next edge -> IDLE, in_valid<=0, input_flag<=0.
- HALTED: absorbing until reset; halt=1; all requests ignored; num holds.
- stall (combinational):
  - 1 in IN_WAIT.
  - 1 in HALTED.
  - 1 in IDLE when io_in_req and not halt_req.
  - 0 in IN_DONE.
- Invariants:
  - output_flag and input_flag never both 1.
  - in_valid high exactly one cycle per IN.
  - num changes only on an accepted OUT.
- OUT latency: num and output_flag are visible one edge after io_out_req is sampled high in IDLE.
- IN latency: in_valid asserts 1 edge after press. press occurs 2 sync + DEBOUNCE_CYCLES + 1 edges after a clean button rise.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> all outputs 0, stall=0 with io_in_req=0; repeat reset while in IN_WAIT -> IDLE, input_flag=0.
- OUT: io_out_req=1 for one cycle, out_data=1234 -> next cycle num=1234, output_flag=1, stall=0 throughout.
- IN with bounce (DEBOUNCE_CYCLES=16): SW=0x0009, io_in_req held, button toggles in 3-cycle glitches then is held high 30 cycles -> stall=1 until press; in_valid high exactly 1 cycle with in_data=9; stall=0 that cycle; input_flag cleared next cycle.
- Held button: button already high when IN issued -> no in_valid while held; release for 20 cycles, press again -> in_valid once.
- Simultaneous: IDLE with io_out_req=io_in_req=1, out_data=7 -> num=7 next cycle, then IN_WAIT, output_flag=0, input_flag=1.
- Halt: halt_req during IN_WAIT -> halt=1, input_flag=0, stall=1; later io_out_req ignored (num unchanged) until reset.
